// File: rtl/gen_big_field_table_pkg.sv
// rtl/gen_big_field_table_pkg.sv - shared types and helpers for the big-field header generator
package gen_big_field_table_pkg;

    // Frame-level states: idle, header emission, header-followed body, untouched body.
    typedef enum logic [1:0] {
        IDLE,
        FIELD,
        BODY,
        BYPASS
    } state_t;

    // Header word index width; a single-word header still needs one counter bit.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gen_big_field_table.sv
// rtl/gen_big_field_table.sv - prepends a latched word array as a stream header, then forwards the payload frame
module gen_big_field_table
    import gen_big_field_table_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int FIELD_LEN  = 16*8,
    parameter     FIELD_NAME = "Big Field"
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [DSIZE-1:0] value [0:FIELD_LEN-1],
    output logic             busy,
    output logic             field_done,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready
);

    localparam int            CW       = counter_width(FIELD_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FIELD_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    counter;
    logic [DSIZE-1:0] shadow [0:FIELD_LEN-1];

    // The frame is in flight whenever we have left IDLE.
    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the header array at frame start and step through it on each accepted header beat.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            counter <= '0;
            for (int i = 0; i < FIELD_LEN; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == IDLE && s_tvalid && enable) begin
            counter <= '0;
            shadow  <= value;
        end else if (state == FIELD && m_tready && counter != LAST_IDX) begin
            counter <= counter + CW'(1);
        end
    end

    // Next state and stream steering; header beats come from the shadow copy, body beats pass straight through.
    always_comb begin
        state_next = state;
        m_tdata    = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        s_tready   = 1'b0;
        field_done = 1'b0;
        case (state)
            IDLE: begin
                if (s_tvalid) begin
                    state_next = enable ? FIELD : BYPASS;
                end
            end
            FIELD: begin
                m_tdata  = shadow[counter];
                m_tvalid = 1'b1;
                if (m_tready && counter == LAST_IDX) begin
                    field_done = 1'b1;
                    state_next = BODY;
                end
            end
            BODY, BYPASS: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast;
                s_tready = m_tready;
                if (s_tvalid && m_tready && s_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Downstream data must not move while a beat is offered but not yet taken.
    hold_while_stalled: assert property (
        @(posedge clock) disable iff (rst)
        (m_tvalid && !m_tready) |=> $stable(m_tdata)
    ) else $error("%s: m_tdata changed while stalled", FIELD_NAME);

endmodule

// File: tb/tb_gen_big_field_table.sv
// tb/tb_gen_big_field_table.sv - scoreboard bench for gen_big_field_table at header lengths 4, 1 and 128
module tb_gen_big_field_table;

    logic       clock;
    logic       rst;
    logic       enable     [3];
    logic       busy       [3];
    logic       field_done [3];
    logic [7:0] s_tdata    [3];
    logic       s_tvalid   [3];
    logic       s_tlast    [3];
    logic       s_tready   [3];
    logic [7:0] m_tdata    [3];
    logic       m_tvalid   [3];
    logic       m_tlast    [3];
    logic       m_tready   [3];

    logic [7:0] value4   [0:3];
    logic [7:0] value1   [0:0];
    logic [7:0] value128 [0:127];

    // entry = {header, field_done, tlast, data}
    logic [10:0] exp_q [$];
    int          act;
    int          n_checks;
    int          n_fail;

    gen_big_field_table #(.DSIZE(8), .FIELD_LEN(4), .FIELD_NAME("F4")) dut4 (
        .clock(clock), .rst(rst), .enable(enable[0]), .value(value4),
        .busy(busy[0]), .field_done(field_done[0]),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tlast(s_tlast[0]), .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .m_tready(m_tready[0])
    );

    gen_big_field_table #(.DSIZE(8), .FIELD_LEN(1), .FIELD_NAME("F1")) dut1 (
        .clock(clock), .rst(rst), .enable(enable[1]), .value(value1),
        .busy(busy[1]), .field_done(field_done[1]),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tlast(s_tlast[1]), .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .m_tready(m_tready[1])
    );

    gen_big_field_table #(.DSIZE(8), .FIELD_LEN(128), .FIELD_NAME("F128")) dut128 (
        .clock(clock), .rst(rst), .enable(enable[2]), .value(value128),
        .busy(busy[2]), .field_done(field_done[2]),
        .s_tdata(s_tdata[2]), .s_tvalid(s_tvalid[2]), .s_tlast(s_tlast[2]), .s_tready(s_tready[2]),
        .m_tdata(m_tdata[2]), .m_tvalid(m_tvalid[2]), .m_tlast(m_tlast[2]), .m_tready(m_tready[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic rdy(input int mode, input int c);
        return (mode == 0) ? 1'b1 : (c % 3 == 0);
    endfunction

    task automatic push(input bit hdr, input bit fd, input bit last, input logic [7:0] d);
        exp_q.push_back({hdr, fd, last, d});
    endtask

    // Scoreboard: every downstream handshake pops one expected beat.
    task automatic monitor();
        logic       mv, mr, ml, fd, sr, prev_stall;
        logic [7:0] md, prev_data;
        logic [10:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                mv = m_tvalid[act]; mr = m_tready[act]; md = m_tdata[act];
                ml = m_tlast[act];  fd = field_done[act]; sr = s_tready[act];
                if (prev_stall && mv) begin
                    n_checks++;
                    if (md !== prev_data) begin
                        n_fail++;
                        $display("FAIL stall_hold: m_tdata=%h required %h", md, prev_data);
                    end
                end
                if (mv && mr) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat: got data=%h last=%b, required no beat", md, ml);
                    end else begin
                        e = exp_q.pop_front();
                        if ({fd, ml, md} !== e[9:0]) begin
                            n_fail++;
                            $display("FAIL beat: fd/last/data=%b/%b/%h required %b/%b/%h",
                                     fd, ml, md, e[9], e[8], e[7:0]);
                        end
                        if (e[10]) begin
                            n_checks++;
                            if (sr !== 1'b0) begin
                                n_fail++;
                                $display("FAIL hdr_s_tready: s_tready=%b required 0", sr);
                            end
                        end
                    end
                end else begin
                    n_checks++;
                    if (fd !== 1'b0) begin
                        n_fail++;
                        $display("FAIL field_done_no_hs: field_done=%b required 0", fd);
                    end
                end
                prev_stall = mv && !mr;
                prev_data  = md;
            end
        end
    endtask

    // Upstream source: offers body beats, holding each until accepted; m_tready follows the chosen pattern.
    task automatic drive_frame(input int k, input bit en, input logic [7:0] body [$],
                               input int rmode, output int first_valid);
        int idx;
        int cyc;
        bit seen;
        bit hs;
        idx = 0; cyc = 0; seen = 0; first_valid = -1;
        enable[k]   = en;
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = body[0];
        s_tlast[k]  = (body.size() == 1);
        m_tready[k] = rdy(rmode, 0);
        while (idx < body.size() && cyc < 2000) begin
            @(negedge clock);
            if (!seen && m_tvalid[k]) begin
                seen = 1;
                first_valid = cyc;
            end
            hs = s_tvalid[k] && s_tready[k];
            @(posedge clock);
            #1;
            cyc++;
            if (hs) begin
                idx++;
                if (idx < body.size()) begin
                    s_tdata[k] = body[idx];
                    s_tlast[k] = (idx == body.size() - 1);
                end
            end
            m_tready[k] = rdy(rmode, cyc);
        end
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
        if (idx < body.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: %0d of %0d body beats accepted", idx, body.size());
        end
    endtask

    task automatic check_end(input int k, input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_end: busy=%b required 0", name, busy[k]);
        end
    endtask

    task automatic test_reset();
        s_tvalid[0] = 1'b1; enable[0] = 1'b1; m_tready[0] = 1'b1; s_tdata[0] = 8'h33; s_tlast[0] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks += 6;
        if (m_tvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: %b required 0", m_tvalid[0]); end
        if (m_tdata[0] !== 8'h00) begin n_fail++; $display("FAIL rst_m_tdata: %h required 00", m_tdata[0]); end
        if (m_tlast[0] !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: %b required 0", m_tlast[0]); end
        if (s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: %b required 0", s_tready[0]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b required 0", busy[0]); end
        if (field_done[0] !== 1'b0) begin n_fail++; $display("FAIL rst_field_done: %b required 0", field_done[0]); end
        s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
        rst = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_field4(input int rmode, input string name);
        logic [7:0] bq [$];
        int fv;
        act = 0;
        for (int i = 0; i < 4; i++) value4[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 4; i++) push(1, i == 3, 0, 8'(8'hA0 + i));
        push(0, 0, 0, 8'h10); push(0, 0, 0, 8'h11); push(0, 0, 1, 8'h12);
        bq = '{8'h10, 8'h11, 8'h12};
        drive_frame(0, 1'b1, bq, rmode, fv);
        n_checks++;
        if (fv != 1) begin n_fail++; $display("FAIL %s_latency: first valid at cycle %0d required 1", name, fv); end
        check_end(0, name);
    endtask

    task automatic test_bypass();
        logic [7:0] bq [$];
        int fv;
        act = 0;
        push(0, 0, 0, 8'h55); push(0, 0, 1, 8'h66);
        bq = '{8'h55, 8'h66};
        drive_frame(0, 1'b0, bq, 0, fv);
        n_checks++;
        if (fv != 1) begin n_fail++; $display("FAIL bypass_latency: first valid at cycle %0d required 1", fv); end
        check_end(0, "bypass");
    endtask

    task automatic test_len1_b2b();
        logic [7:0] bq [$];
        int fv;
        act = 1;
        value1[0] = 8'h7E;
        bq = '{8'h01};
        for (int f = 0; f < 2; f++) begin
            push(1, 1, 0, 8'h7E); push(0, 0, 1, 8'h01);
            drive_frame(1, 1'b1, bq, 0, fv);
            n_checks++;
            if (fv != 1) begin n_fail++; $display("FAIL len1_bubble_f%0d: first valid at cycle %0d required 1", f, fv); end
            check_end(1, "len1");
        end
    endtask

    task automatic test_shadow128();
        logic [7:0] bq [$];
        int fv;
        act = 2;
        for (int i = 0; i < 128; i++) value128[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 128; i++) push(1, i == 127, 0, 8'(i * 3 + 1));
        push(0, 0, 1, 8'h99);
        bq = '{8'h99};
        fork
            drive_frame(2, 1'b1, bq, 0, fv);
            begin
                repeat (3) @(posedge clock);
                #2;
                for (int i = 0; i < 128; i++) value128[i] = 8'hFF;
                enable[2] = 1'b0;
            end
        join
        n_checks++;
        if (fv != 1) begin n_fail++; $display("FAIL shadow_latency: first valid at cycle %0d required 1", fv); end
        check_end(2, "shadow128");
    endtask

    task automatic test_reset_mid();
        logic [7:0] bq [$];
        int fv;
        act = 0;
        for (int i = 0; i < 4; i++) value4[i] = 8'(8'hA0 + i);
        push(1, 0, 0, 8'hA0); push(1, 0, 0, 8'hA1);
        enable[0] = 1'b1; s_tvalid[0] = 1'b1; s_tdata[0] = 8'h10; s_tlast[0] = 1'b0; m_tready[0] = 1'b1;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_idle: busy=%b required 0", busy[0]); end
        @(posedge clock);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_rise: busy=%b required 1", busy[0]); end
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (m_tvalid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_m_tvalid: %b required 0", m_tvalid[0]); end
        if (s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_s_tready: %b required 0", s_tready[0]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: %b required 0", busy[0]); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_sent: %0d header beats unsent, required 0", exp_q.size()); end
        exp_q.delete();
        s_tvalid[0] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) push(1, i == 3, 0, 8'(8'hA0 + i));
        push(0, 0, 0, 8'h10); push(0, 0, 1, 8'h11);
        bq = '{8'h10, 8'h11};
        drive_frame(0, 1'b1, bq, 0, fv);
        n_checks++;
        if (fv != 1) begin n_fail++; $display("FAIL restart_latency: first valid at cycle %0d required 1", fv); end
        check_end(0, "restart");
    endtask

    initial begin
        rst = 1'b1;
        act = 0;
        n_checks = 0;
        n_fail = 0;
        for (int k = 0; k < 3; k++) begin
            enable[k] = 1'b0; s_tdata[k] = '0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; m_tready[k] = 1'b0;
        end
        for (int i = 0; i < 4; i++) value4[i] = '0;
        value1[0] = '0;
        for (int i = 0; i < 128; i++) value128[i] = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_field4(0, "field4");
        test_field4(1, "stall4");
        test_bypass();
        test_len1_b2b();
        test_shadow128();
        test_reset_mid();
        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_big_field_table.md
Name: gen_big_field_table

Overview:
- Transmit-side counterpart of the big-field parser.
- Takes a parallel array of FIELD_LEN words and serialises it, one word per beat, onto an AXI-stream master as a frame header.
- Then forwards the upstream payload frame unchanged up to and including its tlast.
- Sits in front of frame builders, so that the downstream big-field parser recovers exactly the same array.

Parameters:
- DSIZE, 8, word width of the stream and of each array element.
- FIELD_LEN, 16*8, number of header words, legal range 1..128.
- FIELD_NAME, "Big Field", label string used only by simulation messages.

Ports:
- clock  input  1  single clock for all logic and both streams.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  sampled at frame start; 1 = prepend field, 0 = bypass the frame untouched.
- value  input  DSIZE x [0:FIELD_LEN-1]  header array; value[0] is transmitted first.
- busy  output  1  high from frame start until the body tlast handshake.
- field_done  output  1  one-cycle pulse on the handshake of the last header beat.
- s_tdata  input  DSIZE  upstream payload data.
- s_tvalid  input  1  upstream valid.
- s_tlast  input  1  upstream end of frame.
- s_tready  output  1  upstream ready.
- m_tdata  output  DSIZE  downstream data.
- m_tvalid  output  1  downstream valid.
- m_tlast  output  1  downstream end of frame.
- m_tready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, shadow array 0. Outputs m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, busy=0, field_done=0.
- Handshake rule: a beat transfers when valid&&ready on the same edge.
- IDLE:
  - s_tready=0 and m_tvalid=0.
  - When s_tvalid=1, sample enable.
  - If enable=1: copy value into the shadow array, counter<=0, go to FIELD.
  - If enable=0: go to BYPASS.
  - busy goes to 1 on the cycle after the transition.
- FIELD:
  - m_tdata=shadow[counter] (registered/shadow path), m_tvalid=1, m_tlast=0, s_tready=0.
  - On handshake: counter<=counter+1.
  - When counter==FIELD_LEN-1 and handshake: field_done pulses, go to BODY.
  - When m_tready=0: counter and data hold and m_tvalid stays 1 (no bubble, no drop).
  - Counter width is $clog2(FIELD_LEN), minimum 1 bit. Compare against FIELD_LEN-1; no wrap is ever used.
  - FIELD_LEN=1: one header beat, then BODY.
- BODY and BYPASS:
  - Combinational pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, m_tlast=s_tlast, s_tready=m_tready.
  - On a handshake with s_tlast=1: go to IDLE, busy=0 next cycle.
- Latency:
  - First header beat is valid one cycle after s_tvalid is first seen in IDLE.
  - After a body tlast handshake, at least one IDLE cycle passes before the next frame starts (back-to-back frames allowed with that single bubble).
- Mid-frame changes:
  - value and enable are ignored while busy; the shadow copy is used.
  - s_tvalid dropping during FIELD has no effect.
- A single-beat body (s_tlast on the first body beat) is legal: header followed by one body beat.
- Reset mid-frame: immediate return to IDLE with all outputs deasserted. The partially sent frame is abandoned; downstream recovery is not this block's job.
- m_tlast is never asserted on a header beat.

Decomposition:
- Shared package: state enum (IDLE, FIELD, BODY, BYPASS) and a function computing the counter width ($clog2 with minimum 1).
- No sub-module: the shadow register plus mux, the counter and the FSM form one module of about 150-250 lines.
- Optional simulation-only assertion block labelled with FIELD_NAME: fires if m_tdata changes while m_tvalid&&!m_tready.

Test Plan:
- FIELD_LEN=4, DSIZE=8, value={8'hA0,8'hA1,8'hA2,8'hA3}, enable=1, body 3 beats 8'h10..8'h12 with tlast on 8'h12, m_tready=1 -> m_tdata sequence A0,A1,A2,A3,10,11,12; m_tlast only on 12; field_done pulses on A3.
- Same frame with m_tready toggling 1,0,0,1,... -> identical sequence; m_tdata stable while stalled; s_tready=0 for all header beats.
- enable=0 at frame start, body 8'h55,8'h66(last) -> output 55,66 only; field_done never pulses.
- FIELD_LEN=1, value={8'h7E}, body single beat 8'h01 with tlast -> output 7E then 01(last); then a second identical frame back-to-back -> exactly one IDLE bubble between frames.
- Change value to all 8'hFF after the first header beat of a FIELD_LEN=128 frame -> all 128 header beats carry the values latched at frame start.
- Assert rst during header beat 2 of 4 -> m_tvalid=0, s_tready=0 immediately; the next frame after release starts again from value[0].
